// File: rtl/uart_responder.sv
// uart_responder: responder end of the core's UART request interface.
// Word-level write requests are split into bytes pushed to a TX byte FIFO
// that drains to the tx PHY. Word-level read requests are assembled from
// bytes popped from an RX byte FIFO that is filled by the rx PHY.
module uart_responder #(
   parameter int FIFO_AW = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        uart_order,
   input  logic        uart_write_flag,
   input  logic [1:0]  uart_size,
   input  logic [31:0] uart_o_data,
   output logic [31:0] uart_i_data,
   output logic        uart_accepted,
   output logic        uart_accessed,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_overrun
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_READ  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // ---------------------------------------------------------------
   // Request state
   // ---------------------------------------------------------------
   logic [1:0]  state;
   logic [1:0]  req_size;
   logic [31:0] wr_data;
   logic [1:0]  idx;
   logic [31:0] rd_buf;
   logic [31:0] rd_buf_next;
   logic [7:0]  wr_byte;
   logic        last_beat;

   // ---------------------------------------------------------------
   // TX FIFO
   // ---------------------------------------------------------------
   logic [7:0]       tx_mem [DEPTH];
   logic [FIFO_AW:0] tx_wr_ptr;
   logic [FIFO_AW:0] tx_rd_ptr;
   logic             tx_empty;
   logic             tx_full;
   logic             tx_push;
   logic             tx_pop;

   // ---------------------------------------------------------------
   // RX FIFO
   // ---------------------------------------------------------------
   logic [7:0]       rx_mem [DEPTH];
   logic [FIFO_AW:0] rx_wr_ptr;
   logic [FIFO_AW:0] rx_rd_ptr;
   logic             rx_empty;
   logic             rx_full;
   logic             rx_push;
   logic             rx_pop;
   logic [7:0]       rx_head;

   // FIFO status flags and handshake qualifiers; full/empty are taken from
   // the pointers before this cycle's updates, so a full FIFO is never
   // refilled by a same-cycle pop.
   always_comb begin
      tx_empty = (tx_wr_ptr == tx_rd_ptr);
      tx_full  = (tx_wr_ptr[FIFO_AW] != tx_rd_ptr[FIFO_AW]) &&
                 (tx_wr_ptr[FIFO_AW-1:0] == tx_rd_ptr[FIFO_AW-1:0]);
      rx_empty = (rx_wr_ptr == rx_rd_ptr);
      rx_full  = (rx_wr_ptr[FIFO_AW] != rx_rd_ptr[FIFO_AW]) &&
                 (rx_wr_ptr[FIFO_AW-1:0] == rx_rd_ptr[FIFO_AW-1:0]);
      tx_push  = (state == ST_WRITE) && !tx_full;
      tx_pop   = !tx_empty && tx_ready;
      rx_push  = rx_valid && !rx_full;
      rx_pop   = (state == ST_READ) && !rx_empty;
      rx_head  = rx_mem[rx_rd_ptr[FIFO_AW-1:0]];
      last_beat = (idx == req_size);
   end

   // Byte lane selection for writes and byte insertion for reads.
   always_comb begin
      wr_byte     = '0;
      rd_buf_next = rd_buf;
      case (idx)
         2'd0: begin
            wr_byte           = wr_data[7:0];
            rd_buf_next[7:0]  = rx_head;
         end
         2'd1: begin
            wr_byte           = wr_data[15:8];
            rd_buf_next[15:8] = rx_head;
         end
         2'd2: begin
            wr_byte            = wr_data[23:16];
            rd_buf_next[23:16] = rx_head;
         end
         default: begin
            wr_byte            = wr_data[31:24];
            rd_buf_next[31:24] = rx_head;
         end
      endcase
   end

   // TX PHY interface: head byte is forced to zero while the FIFO is empty
   // so tx_data reads 0 out of reset without clearing the storage array.
   always_comb begin
      tx_valid = !tx_empty;
      tx_data  = tx_empty ? '0 : tx_mem[tx_rd_ptr[FIFO_AW-1:0]];
   end

   // TX FIFO storage write.
   always_ff @(posedge clk) begin
      if (tx_push) begin
         tx_mem[tx_wr_ptr[FIFO_AW-1:0]] <= wr_byte;
      end
   end

   // TX FIFO pointers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
      end else begin
         if (tx_push) begin
            tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
         end
         if (tx_pop) begin
            tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
         end
      end
   end

   // RX FIFO storage write.
   always_ff @(posedge clk) begin
      if (rx_push) begin
         rx_mem[rx_wr_ptr[FIFO_AW-1:0]] <= rx_data;
      end
   end

   // RX FIFO pointers and sticky overrun on a dropped byte.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rx_wr_ptr  <= '0;
         rx_rd_ptr  <= '0;
         rx_overrun <= 1'b0;
      end else begin
         if (rx_push) begin
            rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
         end
         if (rx_pop) begin
            rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
         end
         if (rx_valid && rx_full) begin
            rx_overrun <= 1'b1;
         end
      end
   end

   // Request sequencer: latch in IDLE, move one byte per cycle in
   // WRITE/READ, pulse completion from DONE. The read result is assembled
   // in rd_buf and only copied to uart_i_data on the final byte, so the
   // previous result stays visible for the whole of a new read.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state         <= ST_IDLE;
         req_size      <= '0;
         wr_data       <= '0;
         idx           <= '0;
         rd_buf        <= '0;
         uart_i_data   <= '0;
         uart_accepted <= 1'b0;
         uart_accessed <= 1'b0;
      end else begin
         uart_accepted <= 1'b0;
         uart_accessed <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (uart_order) begin
                  req_size      <= uart_size;
                  wr_data       <= uart_o_data;
                  idx           <= '0;
                  rd_buf        <= '0;
                  uart_accepted <= 1'b1;
                  state         <= uart_write_flag ? ST_WRITE : ST_READ;
               end
            end
            ST_WRITE: begin
               if (tx_push) begin
                  idx <= idx + 2'd1;
                  if (last_beat) begin
                     uart_accessed <= 1'b1;
                     state         <= ST_DONE;
                  end
               end
            end
            ST_READ: begin
               if (rx_pop) begin
                  idx    <= idx + 2'd1;
                  rd_buf <= rd_buf_next;
                  if (last_beat) begin
                     uart_i_data   <= rd_buf_next;
                     uart_accessed <= 1'b1;
                     state         <= ST_DONE;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
